spike_event_encoder: RTL

Receive-side counterpart to the output spike gating stage. It accepts a 4-line spike vector, groups all spikes that land within a fixed collection window into one event, and encodes it as the winning line index plus a line mask. Encoded events go into a small FIFO and are delivered downstream over a valid/ready handshake. It sits between the spike output lanes and the event-processing logic, such as the label/teacher path or a host readout.

---
 rtl/odesa_pkg.sv | 39 +++
 rtl/spike_event_fifo.sv | 49 ++++
 rtl/spike_event_encoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/odesa_pkg.sv
// Shared definitions for the spike event encoder: lane count, FSM state
// encoding, event record layout and counter widths.
// No ports; imported by spike_event_encoder and friends.
package odesa_pkg;

  localparam int unsigned SPK_LANES = 4;

  // Event record layout, LSB first: mask, id, multi, then optional timestamp.
  localparam int unsigned EVT_MASK_W    = SPK_LANES;
  localparam int unsigned EVT_ID_W      = 2;
  localparam int unsigned EVT_MASK_LSB  = 0;
  localparam int unsigned EVT_ID_LSB    = EVT_MASK_LSB + EVT_MASK_W;
  localparam int unsigned EVT_MULTI_LSB = EVT_ID_LSB + EVT_ID_W;
  localparam int unsigned EVT_TS_LSB    = EVT_MULTI_LSB + 1;
  localparam int unsigned EVT_BASE_W    = EVT_TS_LSB;

  localparam int unsigned DROP_CNT_W = 8;
  localparam int unsigned WIN_CNT_W  = 8;

  typedef enum logic [1:0] {
    ENC_IDLE    = 2'd0,
    ENC_COLLECT = 2'd1,
    ENC_PUSH    = 2'd2
  } enc_state_e;

  // Index of the lowest set lane; 0 for an empty mask.
  function automatic logic [EVT_ID_W-1:0] lowest_lane(input logic [SPK_LANES-1:0] m);
    lowest_lane = '0;
    for (int i = SPK_LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest_lane = EVT_ID_W'(i);
    end
  endfunction

  // More than one bit set: clearing the lowest set bit leaves something.
  function automatic logic multi_lane(input logic [SPK_LANES-1:0] m);
    multi_lane = |(m & (m - 1'b1));
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous first-word-fall-through FIFO; wrap-bit pointers for full/empty.
// Ports: i_clk, i_rst (sync, active high), i_wr_en/i_wr_dat write side,
// o_full (before any same-cycle pop), o_rd_vld/i_rd_rdy/o_rd_dat read side.
module spike_event_fifo #(
  parameter int p_width = 7,
  parameter int p_depth = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [p_width-1:0] i_wr_dat,
  output logic               o_full,
  output logic               o_rd_vld,
  input  logic               i_rd_rdy,
  output logic [p_width-1:0] o_rd_dat
);

  localparam int AW = $clog2(p_depth);

  logic [p_width-1:0] mem_q [p_depth];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic               empty, do_rd, do_wr;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign o_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_rd = !empty && i_rd_rdy;
  // A pop in the same cycle frees the slot being written.
  assign do_wr = i_wr_en && (!o_full || do_rd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (do_rd) rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= i_wr_dat;
  end

  assign o_rd_vld = !empty;
  assign o_rd_dat = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/spike_event_encoder.sv
// Groups spikes on 4 lanes within a p_window-cycle window into one event
// {mask, lowest id, multi[, timestamp]} and queues it for a valid/ready sink.
// Ports: i_clk, i_rst (sync, active high), i_spike, o_event_valid/i_event_ready,
// o_event_id/mask/multi, o_busy, o_drop_cnt; o_event_time only with
// SPIKE_ENC_TIMESTAMP_EN defined.
module spike_event_encoder #(
  parameter int p_window     = 4,
  parameter int p_fifo_depth = 4,
  parameter int p_ts_width   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [3:0]            i_spike,
  output logic                  o_event_valid,
  input  logic                  i_event_ready,
  output logic [1:0]            o_event_id,
  output logic [3:0]            o_event_mask,
  output logic                  o_event_multi,
  output logic                  o_busy,
  output logic [7:0]            o_drop_cnt
`ifdef SPIKE_ENC_TIMESTAMP_EN
  ,
  output logic [p_ts_width-1:0] o_event_time
`endif
);

  import odesa_pkg::*;

  if (p_window < 1 || p_window > 255 || p_fifo_depth < 2 ||
      (p_fifo_depth & (p_fifo_depth - 1)) != 0 || p_ts_width < 1) begin : g_param_err
    $error("spike_event_encoder: illegal parameter value");
  end

`ifdef SPIKE_ENC_TIMESTAMP_EN
  localparam int REC_W = EVT_BASE_W + p_ts_width;
`else
  localparam int REC_W = EVT_BASE_W;
`endif

  // Count value seen in the last window cycle before moving to PUSH.
  localparam logic [WIN_CNT_W-1:0] WIN_LAST = WIN_CNT_W'(p_window - 1);

  enc_state_e             state_q, state_d;
  logic [SPK_LANES-1:0]   mask_q, mask_d;
  logic [WIN_CNT_W-1:0]   win_cnt_q, win_cnt_d;
  logic [DROP_CNT_W-1:0]  drop_q, drop_d;
  logic                   open_win;

  logic                   fifo_wr_en, fifo_full, fifo_rd_vld, evt_pop, fifo_room;
  logic [REC_W-1:0]       fifo_wr_dat, fifo_rd_dat;

`ifdef SPIKE_ENC_TIMESTAMP_EN
  logic [p_ts_width-1:0]  ts_cnt_q, ts_q, ts_d;
`endif

  assign evt_pop   = fifo_rd_vld && i_event_ready;
  assign fifo_room = !fifo_full || evt_pop;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    win_cnt_d  = win_cnt_q;
    drop_d     = drop_q;
    fifo_wr_en = 1'b0;
    open_win   = 1'b0;
`ifdef SPIKE_ENC_TIMESTAMP_EN
    ts_d       = ts_q;
`endif
    case (state_q)
      ENC_IDLE: begin
        open_win = |i_spike;
      end
      ENC_COLLECT: begin
        mask_d    = mask_q | i_spike;
        win_cnt_d = win_cnt_q + 8'd1;
        if (win_cnt_q == WIN_LAST) state_d = ENC_PUSH;
      end
      ENC_PUSH: begin
        fifo_wr_en = fifo_room;
        if (!fifo_room && drop_q != '1) drop_d = drop_q + 8'd1;
        state_d  = ENC_IDLE;
        // Spikes in the PUSH cycle start the next window immediately.
        open_win = |i_spike;
      end
      default: state_d = ENC_IDLE;
    endcase
    if (open_win) begin
      mask_d    = i_spike;
      win_cnt_d = 8'd1;
      state_d   = (p_window == 1) ? ENC_PUSH : ENC_COLLECT;
`ifdef SPIKE_ENC_TIMESTAMP_EN
      ts_d      = ts_cnt_q;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ENC_IDLE;
      mask_q    <= '0;
      win_cnt_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      win_cnt_q <= win_cnt_d;
      drop_q    <= drop_d;
    end
  end

`ifdef SPIKE_ENC_TIMESTAMP_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ts_cnt_q <= '0;
      ts_q     <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + p_ts_width'(1);
      ts_q     <= ts_d;
    end
  end
`endif

  always_comb begin
    fifo_wr_dat = '0;
    fifo_wr_dat[EVT_MASK_LSB +: EVT_MASK_W] = mask_q;
    fifo_wr_dat[EVT_ID_LSB +: EVT_ID_W]     = lowest_lane(mask_q);
    fifo_wr_dat[EVT_MULTI_LSB]              = multi_lane(mask_q);
`ifdef SPIKE_ENC_TIMESTAMP_EN
    fifo_wr_dat[EVT_TS_LSB +: p_ts_width]   = ts_q;
`endif
  end

  spike_event_fifo #(
    .p_width (REC_W),
    .p_depth (p_fifo_depth)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (fifo_wr_en),
    .i_wr_dat (fifo_wr_dat),
    .o_full   (fifo_full),
    .o_rd_vld (fifo_rd_vld),
    .i_rd_rdy (i_event_ready),
    .o_rd_dat (fifo_rd_dat)
  );

  // Fields read as zero while nothing is queued so idle outputs are defined.
  assign o_event_valid = fifo_rd_vld;
  assign o_event_mask  = fifo_rd_vld ? fifo_rd_dat[EVT_MASK_LSB +: EVT_MASK_W] : '0;
  assign o_event_id    = fifo_rd_vld ? fifo_rd_dat[EVT_ID_LSB +: EVT_ID_W] : '0;
  assign o_event_multi = fifo_rd_vld && fifo_rd_dat[EVT_MULTI_LSB];
`ifdef SPIKE_ENC_TIMESTAMP_EN
  assign o_event_time  = fifo_rd_vld ? fifo_rd_dat[EVT_TS_LSB +: p_ts_width] : '0;
`endif
  assign o_busy        = (state_q != ENC_IDLE);
  assign o_drop_cnt    = drop_q;

endmodule
